mem_stage_dmem: RTL and testbench



---
 rtl/mem_stage_dmem.sv | 127 ++++++++++++
 tb/tb_mem_stage_dmem.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_dmem.sv
// MEM-stage data memory responder: word-addressed array with a fixed access latency,
// producing ReadData with a one-cycle ready pulse for the MEM/WB register.
module mem_stage_dmem #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned ADDR_BITS   = 8,
    parameter int unsigned LATENCY     = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        ready,
    output logic        busy,
    output logic        misaligned
);
    localparam int unsigned CNT_W = 4;
    localparam int unsigned LOW_W = ADDR_BITS + 2;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               op_rd;
    logic               op_wr;
    logic [LOW_W-1:0]   addr_q;
    logic [31:0]        wdata_q;
    logic [31:0]        mem [DEPTH_WORDS];

    logic               req;
    logic               acc_en;
    logic               acc_rd;
    logic               acc_wr;
    logic [LOW_W-1:0]   acc_addr;
    logic [31:0]        acc_wdata;
    logic               acc_mis;
    logic [ADDR_BITS-1:0] acc_idx;
    logic               addr_unused;

    assign req         = MemRead | MemWrite;
    assign addr_unused = ^Address[31:LOW_W];
    assign ready       = !reset && ((state == IDLE && !req) || state == DONE);

    // Access happens on the edge entering DONE; with unit latency that is the accept edge itself.
    always_comb begin
        acc_en    = 1'b0;
        acc_rd    = op_rd;
        acc_wr    = op_wr;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        if (state == IDLE && req && LATENCY == 1) begin
            acc_en    = 1'b1;
            acc_rd    = MemRead;
            acc_wr    = MemWrite;
            acc_addr  = Address[LOW_W-1:0];
            acc_wdata = WriteData;
        end else if (state == BUSY && cnt == CNT_W'(1)) begin
            acc_en = 1'b1;
        end
        acc_mis = (acc_addr[1:0] != 2'b00);
        acc_idx = acc_addr[LOW_W-1:2];
    end

    // Array is never cleared; reset only blocks a commit.
    always_ff @(posedge clk) begin
        if (!reset && acc_en && acc_wr && !acc_mis) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            op_rd      <= 1'b0;
            op_wr      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            ReadData   <= '0;
            busy       <= 1'b0;
            misaligned <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    misaligned <= 1'b0;
                    if (req) begin
                        op_rd   <= MemRead;
                        op_wr   <= MemWrite;
                        addr_q  <= Address[LOW_W-1:0];
                        wdata_q <= WriteData;
                        cnt     <= CNT_W'(LATENCY - 1);
                        if (LATENCY == 1) begin
                            state <= DONE;
                            busy  <= 1'b0;
                        end else begin
                            state <= BUSY;
                            busy  <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    misaligned <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
            if (acc_en) begin
                misaligned <= acc_mis;
                if (!acc_mis && acc_rd && !acc_wr) begin
                    ReadData <= mem[acc_idx];
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_stage_dmem.sv
// Bench for mem_stage_dmem: directed vector table, multi-cycle corner sequences,
// and randomized traffic checked against a plain array model.
module tb_mem_stage_dmem;
    localparam int unsigned LAT0 = 3;
    localparam int unsigned LAT1 = 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        r0 = 1'b0, w0 = 1'b0, r1 = 1'b0, w1 = 1'b0;
    logic [31:0] a0 = '0, d0 = '0, a1 = '0, d1 = '0;
    logic [31:0] rd0, rd1;
    logic        rdy0, rdy1, bz0, bz1, mis0, mis1;

    mem_stage_dmem #(.DEPTH_WORDS(256), .ADDR_BITS(8), .LATENCY(LAT0)) dut (
        .clk(clk), .reset(reset), .MemRead(r0), .MemWrite(w0), .Address(a0),
        .WriteData(d0), .ReadData(rd0), .ready(rdy0), .busy(bz0), .misaligned(mis0)
    );

    mem_stage_dmem #(.DEPTH_WORDS(256), .ADDR_BITS(8), .LATENCY(LAT1)) dut1 (
        .clk(clk), .reset(reset), .MemRead(r1), .MemWrite(w1), .Address(a1),
        .WriteData(d1), .ReadData(rd1), .ready(rdy1), .busy(bz1), .misaligned(mis1)
    );

    int tests = 0;
    int fails = 0;
    logic [31:0] model [256];
    logic [31:0] model_rd;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_mis;
    } vec_t;
    vec_t tbl [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (sel) begin r1 = rd; w1 = wr; a1 = addr; d1 = wdata; end
        else     begin r0 = rd; w0 = wr; a0 = addr; d0 = wdata; end
    endtask

    // Issue one request starting just after a rising edge; returns results at the ready pulse.
    task automatic req(input bit sel, input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input bit scramble,
                       output logic [31:0] rdata, output logic mis, output int low, output int bcnt);
        bit done = 1'b0;
        low = 0; bcnt = 0; rdata = '0; mis = 1'b0;
        drive(sel, rd, wr, addr, wdata);
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (sel ? rdy1 : rdy0) begin
                rdata = sel ? rd1 : rd0;
                mis   = sel ? mis1 : mis0;
                done  = 1'b1;
            end else begin
                low++;
                if (sel ? bz1 : bz0) begin
                    bcnt++;
                    if (scramble) drive(sel, rd, wr, $urandom, $urandom);
                end
            end
        end
        if (!done) chk("ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        drive(sel, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic run_check(input string nm, input bit sel, input logic rd, input logic wr,
                             input logic [31:0] addr, input logic [31:0] wdata, input bit scramble,
                             input logic [31:0] exp_rd, input logic exp_mis, input int lat);
        logic [31:0] got; logic m; int low; int bc;
        req(sel, rd, wr, addr, wdata, scramble, got, m, low, bc);
        chk({nm, "_rdata"}, got, exp_rd);
        chk({nm, "_mis"}, 32'(m), 32'(exp_mis));
        chk({nm, "_lat"}, 32'(low), 32'(lat));
        chk({nm, "_busy"}, 32'(bc), 32'(lat - 1));
    endtask

    initial begin
        logic [31:0] addr, wdata, exp_rd;
        logic rd, wr, mis;
        logic [7:0] idx;

        // Reset held two cycles with no requests.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_ready0", 32'(rdy0), 32'd0);
            chk("rst_ready1", 32'(rdy1), 32'd0);
            if (i == 1) begin
                chk("rst_rdata0", rd0, 32'd0);
                chk("rst_rdata1", rd1, 32'd0);
                chk("rst_busy", 32'(bz0), 32'd0);
                chk("rst_mis", 32'(mis0), 32'd0);
            end
        end
        @(posedge clk); #1; reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_ready0", 32'(rdy0), 32'd1);
            chk("idle_ready1", 32'(rdy1), 32'd1);
        end
        @(posedge clk); #1;

        tbl[0] = '{1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0};
        tbl[1] = '{1'b1, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 32'h404, 32'h12345678, 32'hDEADBEEF, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 32'h4,   32'h0,        32'h12345678, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 32'h13,  32'h0,        32'hDEADBEEF, 1'b1};
        tbl[6] = '{1'b0, 1'b1, 32'h11,  32'hFFFFFFFF, 32'hDEADBEEF, 1'b1};
        tbl[7] = '{1'b1, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
        for (int i = 0; i < 8; i++) begin
            run_check($sformatf("vec%0d", i), 1'b0, tbl[i].rd, tbl[i].wr, tbl[i].addr,
                      tbl[i].wdata, 1'b0, tbl[i].exp_rd, tbl[i].exp_mis, int'(LAT0));
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("hold_rdata", rd0, 32'hDEADBEEF);
        end
        @(posedge clk); #1;

        // Reset during the second BUSY cycle aborts the store.
        run_check("pre_sw", 1'b0, 1'b0, 1'b1, 32'h20, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0, int'(LAT0));
        drive(1'b0, 1'b0, 1'b1, 32'h20, 32'hAAAA5555);
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk("midrst_ready", 32'(rdy0), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_busy", 32'(bz0), 32'd0);
        chk("midrst_rdata", rd0, 32'd0);
        chk("midrst_ready_idle", 32'(rdy0), 32'd1);
        @(posedge clk); #1;
        run_check("midrst_lw", 1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 32'h0, 1'b0, int'(LAT0));

        // Unit latency with a combined read+write treated as a store.
        run_check("lat1_both", 1'b1, 1'b1, 1'b1, 32'h8, 32'h1, 1'b0, 32'h0, 1'b0, int'(LAT1));
        run_check("lat1_lw", 1'b1, 1'b1, 1'b0, 32'h8, 32'h0, 1'b0, 32'h1, 1'b0, int'(LAT1));

        // Fill the whole array so the model knows every word.
        model_rd = 32'h0;
        for (int i = 0; i < 256; i++) begin
            wdata = $urandom;
            model[i] = wdata;
            run_check("init_sw", 1'b0, 1'b0, 1'b1, 32'(i * 4), wdata, 1'b1, model_rd, 1'b0, int'(LAT0));
        end

        for (int n = 0; n < 200; n++) begin
            int t;
            t = int'($urandom_range(0, 3));
            addr = $urandom;
            addr[1:0] = 2'b00;
            wdata = $urandom;
            rd = (t == 0 || t == 2);
            wr = (t == 1 || t == 2);
            if (t == 3) begin
                addr[1:0] = 2'($urandom_range(1, 3));
                rd = $urandom_range(0, 1) == 1;
                wr = !rd;
            end
            idx = 8'((addr % 32'd1024) / 32'd4);
            mis = (addr % 32'd4) != 32'd0;
            if (!mis) begin
                if (wr) model[idx] = wdata;
                else    model_rd = model[idx];
            end
            exp_rd = model_rd;
            run_check($sformatf("rnd%0d", n), 1'b0, rd, wr, addr, wdata, 1'b1, exp_rd, mis, int'(LAT0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
